// File: rtl/program_loader.sv
// program_loader: packs a UART byte stream MSB-first into 32-bit words
// and writes them to instruction memory from address 0 until HALT or full.
module program_loader #(
    parameter int LEN_ADDR  = 7,
    parameter int LEN_DATA  = 32,
    parameter int RAM_DEPTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    output logic                wr_en,
    output logic [LEN_ADDR-1:0] wr_addr,
    output logic [LEN_DATA-1:0] wr_data,
    output logic                busy,
    output logic                load_done,
    output logic                overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_ADDR-1:0] LAST_ADDR = LEN_ADDR'(RAM_DEPTH - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [23:0]         r_shift;
    logic [1:0]          r_byte_cnt;
    logic [LEN_ADDR-1:0] r_wr_addr;
    logic [LEN_DATA-1:0] r_wr_data;
    logic                r_overflow;

    logic                w_halt;
    logic                w_last;
    logic                w_word_done;

    assign w_halt      = (r_wr_data[31:26] == 6'b111111);
    assign w_last      = (r_wr_addr == LAST_ADDR);
    assign w_word_done = rx_done && (r_byte_cnt == 2'd3);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; WRITE always lasts exactly one cycle
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next_state = RECV;
            end
            RECV: begin
                if (w_word_done) w_next_state = WRITE;
            end
            WRITE: begin
                if (w_halt || w_last) w_next_state = DONE;
                else                  w_next_state = RECV;
            end
            DONE: begin
                if (start) w_next_state = RECV;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: byte packing, address stepping and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_wr_addr  <= '0;
                        r_byte_cnt <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (rx_done) begin
                        r_shift    <= {r_shift[15:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wr_data <= {r_shift, rx_data};
                        end
                    end
                end
                WRITE: begin
                    if (!w_halt && w_last) begin
                        r_overflow <= 1'b1;
                    end
                    // A byte arriving here starts the next word
                    if (!w_halt && !w_last) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (rx_done) begin
                            r_shift    <= {r_shift[15:0], rx_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en     = (r_state == WRITE);
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state == RECV) || (r_state == WRITE);
    assign load_done = (r_state == DONE);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed vectors for program_loader built with a
// 4-entry memory so the full-memory stop is reachable quickly.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        load_done;
    logic        overflow;

    int n_cmp;
    int n_err;
    int wr_seen;

    program_loader #(
        .LEN_ADDR (7),
        .LEN_DATA (32),
        .RAM_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .load_done(load_done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [6:0] a,
                             input logic [31:0] d);
        chk({tag, ".en"}, 32'(wr_en), 32'd1);
        chk({tag, ".addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".data"}, wr_data, d);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".en"}, 32'(wr_en), 32'd0);
        chk({tag, ".addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ".data"}, wr_data, 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(load_done), 32'd0);
        chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tick();
        tick();
        chk_zero("rst");
        reset = 1'b0;

        // bytes before start are ignored
        send_word(32'h12345678);
        chk("idle.en", 32'(wr_en), 32'd0);
        chk("idle.busy", 32'(busy), 32'd0);

        // single word
        pulse_start();
        chk("start.busy", 32'(busy), 32'd1);
        send_word(32'h20010005);
        chk_write("w1", 7'd0, 32'h20010005);
        tick();
        chk("w1.en_off", 32'(wr_en), 32'd0);
        chk("w1.busy", 32'(busy), 32'd1);
        chk("w1.next", 32'(wr_addr), 32'd1);

        // HALT load
        do_reset();
        pulse_start();
        send_word(32'h8C010004);
        chk_write("h0", 7'd0, 32'h8C010004);
        tick();
        send_word(32'hFC000000);
        chk_write("h1", 7'd1, 32'hFC000000);
        tick();
        chk("h.done", 32'(load_done), 32'd1);
        chk("h.ovf", 32'(overflow), 32'd0);
        chk("h.busy", 32'(busy), 32'd0);
        chk("h.en", 32'(wr_en), 32'd0);
        chk("h.addr", 32'(wr_addr), 32'd1);
        wr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h55);
            if (wr_en) wr_seen++;
            tick();
            if (wr_en) wr_seen++;
        end
        chk("h.no_wr", 32'(wr_seen), 32'd0);
        chk("h.hold", 32'(load_done), 32'd1);

        // memory full without HALT
        do_reset();
        pulse_start();
        send_word(32'h00000001);
        chk_write("o0", 7'd0, 32'h00000001);
        tick();
        send_word(32'h00000002);
        chk_write("o1", 7'd1, 32'h00000002);
        tick();
        send_word(32'h00000003);
        chk_write("o2", 7'd2, 32'h00000003);
        tick();
        send_word(32'h00000004);
        chk_write("o3", 7'd3, 32'h00000004);
        tick();
        chk("o.done", 32'(load_done), 32'd1);
        chk("o.ovf", 32'(overflow), 32'd1);
        chk("o.addr", 32'(wr_addr), 32'd3);
        chk("o.en", 32'(wr_en), 32'd0);

        // restart from DONE
        pulse_start();
        chk("rs.done", 32'(load_done), 32'd0);
        chk("rs.ovf", 32'(overflow), 32'd0);
        chk("rs.busy", 32'(busy), 32'd1);
        chk("rs.addr", 32'(wr_addr), 32'd0);
        send_word(32'h01020304);
        chk_write("rs", 7'd0, 32'h01020304);
        tick();

        // reset mid-word discards partial bytes
        send_byte(8'hE1);
        send_byte(8'hE2);
        do_reset();
        chk_zero("mid");
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        // 4th byte, then keep rx_done high through the WRITE cycle
        rx_data = 8'h44;
        rx_done = 1'b1;
        tick();
        chk_write("m0", 7'd0, 32'h11223344);
        rx_data = 8'hAA;
        tick();
        rx_done = 1'b0;
        chk("m0.en_off", 32'(wr_en), 32'd0);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk_write("m1", 7'd1, 32'hAABBCCDD);
        tick();
        chk("m1.en_off", 32'(wr_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
